// File: rtl/hack_cpu_mc_pkg.sv
// Shared types and C-instruction field positions for the multi-cycle Hack core.
package hack_cpu_mc_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    RD     = 2'd2,
    WR     = 2'd3
  } state_t;

  localparam int C_A_BIT  = 12;
  localparam int C_ZX_BIT = 11;
  localparam int C_NX_BIT = 10;
  localparam int C_ZY_BIT = 9;
  localparam int C_NY_BIT = 8;
  localparam int C_F_BIT  = 7;
  localparam int C_NO_BIT = 6;
  localparam int C_DA_BIT = 5;
  localparam int C_DD_BIT = 4;
  localparam int C_DM_BIT = 3;

  localparam int J_LT_BIT = 2;
  localparam int J_EQ_BIT = 1;
  localparam int J_GT_BIT = 0;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    logic po;
    po = ~zr & ~ng;
    return (j[J_LT_BIT] & ng) | (j[J_EQ_BIT] & zr) | (j[J_GT_BIT] & po);
  endfunction

endpackage

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU at an arbitrary data width, with zero/negative flags.
module hack_alu_w #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic              i_zx,
  input  logic              i_nx,
  input  logic              i_zy,
  input  logic              i_ny,
  input  logic              i_f,
  input  logic              i_no,
  output logic [DATA_W-1:0] o_out,
  output logic              o_zr,
  output logic              o_ng
);

  logic [DATA_W-1:0] w_x1, w_x2, w_y1, w_y2, w_f;

  always_comb begin
    w_x1  = i_zx ? '0 : i_x;
    w_x2  = i_nx ? ~w_x1 : w_x1;
    w_y1  = i_zy ? '0 : i_y;
    w_y2  = i_ny ? ~w_y1 : w_y1;
    w_f   = i_f ? (w_x2 + w_y2) : (w_x2 & w_y2);
    o_out = i_no ? ~w_f : w_f;
    o_zr  = (o_out == '0);
    o_ng  = o_out[DATA_W-1];
  end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked fetch and data memory.
// Optional performance counters are compiled in with HACK_CPU_MC_PERF_EN.
module hack_cpu_mc
  import hack_cpu_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ready,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt,
  output logic [1:0]        dbg_state,
  output logic [DATA_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_d
);

  // Handshakes: a request (instr_req, mem_rd, mem_wr) holds with stable
  // address/data until the matching instr_valid/mem_ready is seen high on a
  // rising edge; responses arriving outside the owning state are ignored.

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_ir, r_a, r_d, r_res;
  logic [ADDR_W-1:0] r_pc;
  logic              r_res_zr, r_res_ng;

  logic              w_commit, w_latch;
  logic              w_is_c, w_a_sel, w_dest_a, w_dest_d, w_dest_m;
  logic [DATA_W-1:0] w_alu_y, w_alu_out, w_cres;
  logic              w_alu_zr, w_alu_ng, w_czr, w_cng, w_jump;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_is_c   = r_ir[DATA_W-1];
  assign w_a_sel  = r_ir[C_A_BIT];
  assign w_dest_a = r_ir[C_DA_BIT];
  assign w_dest_d = r_ir[C_DD_BIT];
  assign w_dest_m = r_ir[C_DM_BIT];
  assign w_alu_y  = w_a_sel ? mem_rd_data : r_a;

  hack_alu_w #(.DATA_W(DATA_W)) u_alu (
    .i_x  (r_d),
    .i_y  (w_alu_y),
    .i_zx (r_ir[C_ZX_BIT]),
    .i_nx (r_ir[C_NX_BIT]),
    .i_zy (r_ir[C_ZY_BIT]),
    .i_ny (r_ir[C_NY_BIT]),
    .i_f  (r_ir[C_F_BIT]),
    .i_no (r_ir[C_NO_BIT]),
    .o_out(w_alu_out),
    .o_zr (w_alu_zr),
    .o_ng (w_alu_ng)
  );

  // In WR the read data is gone, so commit from the latched result and flags.
  assign w_cres   = (r_state == WR) ? r_res    : w_alu_out;
  assign w_czr    = (r_state == WR) ? r_res_zr : w_alu_zr;
  assign w_cng    = (r_state == WR) ? r_res_ng : w_alu_ng;
  assign w_jump   = jump_taken(r_ir[2:0], w_czr, w_cng);
  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_latch   = 1'b0;
    instr_req = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (r_state)
      FETCH: begin
        instr_req = reset;
        if (instr_valid) w_next = DECODE;
      end
      DECODE: begin
        if (!w_is_c) begin
          w_commit = 1'b1;
          w_next   = FETCH;
        end else if (w_a_sel) begin
          w_next = RD;
        end else if (w_dest_m) begin
          w_latch = 1'b1;
          w_next  = WR;
        end else begin
          w_commit = 1'b1;
          w_next   = FETCH;
        end
      end
      RD: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          if (w_dest_m) begin
            w_latch = 1'b1;
            w_next  = WR;
          end else begin
            w_commit = 1'b1;
            w_next   = FETCH;
          end
        end
      end
      WR: begin
        mem_wr = 1'b1;
        if (mem_ready) begin
          w_commit = 1'b1;
          w_next   = FETCH;
        end
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= FETCH;
      r_ir     <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_pc     <= '0;
      r_res    <= '0;
      r_res_zr <= 1'b0;
      r_res_ng <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && instr_valid) r_ir <= instr;
      if (w_latch) begin
        r_res    <= w_alu_out;
        r_res_zr <= w_alu_zr;
        r_res_ng <= w_alu_ng;
      end
      if (w_commit) begin
        if (!w_is_c) begin
          r_a  <= {1'b0, r_ir[DATA_W-2:0]};
          r_pc <= w_pc_inc;
        end else begin
          if (w_dest_a) r_a <= w_cres;
          if (w_dest_d) r_d <= w_cres;
          r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
        end
      end
    end
  end

  assign instr_addr  = r_pc;
  assign mem_addr    = r_a[ADDR_W-1:0];
  assign mem_wr_data = r_res;
  assign dbg_state   = r_state;
  assign dbg_a       = r_a;
  assign dbg_d       = r_d;

`ifdef HACK_CPU_MC_PERF_EN
  logic [31:0] r_retired, r_stall;
  logic        w_stall;

  assign w_stall = (instr_req & ~instr_valid) | ((mem_rd | mem_wr) & ~mem_ready);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_retired <= '0;
      r_stall   <= '0;
    end else begin
      if (w_commit) r_retired <= r_retired + 32'd1;
      if (w_stall)  r_stall   <= r_stall + 32'd1;
    end
  end

  assign retired_cnt = r_retired;
  assign stall_cnt   = r_stall;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: instruction ROM, wait-stated data memory,
// and a write scoreboard fed by expected (addr,data) pairs.
module tb_hack_cpu_mc;
  import hack_cpu_mc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          instr_req, instr_valid, mem_rd, mem_wr, mem_ready;
  logic [AW-1:0] instr_addr, mem_addr;
  logic [DW-1:0] instr, mem_wr_data, mem_rd_data, dbg_a, dbg_d;
  logic [31:0]   retired_cnt, stall_cnt;
  logic [1:0]    dbg_state;

  logic          instr_req_w, mem_rd_w, mem_wr_w;
  logic [19:0]   instr_addr_w, mem_addr_w;
  logic [23:0]   instr_w, mem_wr_data_w, dbg_a_w, dbg_d_w;
  logic [23:0]   mem_rd_data_w;
  logic          instr_valid_w, mem_ready_w;
  logic [31:0]   retired_cnt_w, stall_cnt_w;
  logic [1:0]    dbg_state_w;

  logic [DW-1:0] imem [0:255];
  logic [DW-1:0] dmem [0:15];
  int            wait_n = 0;
  int            total = 0;
  int            bad = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clock = ~clock;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clock(clock), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr(instr), .instr_valid(instr_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state), .dbg_a(dbg_a), .dbg_d(dbg_d)
  );

  hack_cpu_mc #(.DATA_W(24), .ADDR_W(20)) u_dut24 (
    .clock(clock), .reset(reset),
    .instr_req(instr_req_w), .instr_addr(instr_addr_w), .instr(instr_w), .instr_valid(instr_valid_w),
    .mem_rd(mem_rd_w), .mem_wr(mem_wr_w), .mem_addr(mem_addr_w), .mem_wr_data(mem_wr_data_w),
    .mem_rd_data(mem_rd_data_w), .mem_ready(mem_ready_w),
    .retired_cnt(retired_cnt_w), .stall_cnt(stall_cnt_w),
    .dbg_state(dbg_state_w), .dbg_a(dbg_a_w), .dbg_d(dbg_d_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction ROM: zero-wait, valid held high.
  initial begin
    instr_w       = 24'h7ABCDE;
    instr_valid_w = 1'b1;
    mem_rd_data_w = '0;
    mem_ready_w   = 1'b0;
    instr_valid   = 1'b0;
    instr         = '0;
    forever begin
      @(negedge clock);
      instr       = imem[instr_addr[7:0]];
      instr_valid = 1'b1;
    end
  end

  // Data memory: answers after wait_n idle cycles of a held request.
  initial begin
    int cnt;
    cnt         = 0;
    mem_ready   = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clock);
      if (reset && (mem_rd || mem_wr)) begin
        if (cnt >= wait_n) begin
          mem_ready = 1'b1;
          if (mem_rd) mem_rd_data = dmem[mem_addr[3:0]];
          else        dmem[mem_addr[3:0]] = mem_wr_data;
          cnt = 0;
        end else begin
          mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        cnt       = 0;
      end
    end
  end

  // Monitor: request hygiene and write scoreboard.
  initial begin
    logic          pend;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [AW+DW-1:0] e;
    pend = 1'b0;
    pend_addr = '0;
    pend_data = '0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (mem_rd || mem_wr) check("rd_wr_exclusive", {63'd0, mem_rd & mem_wr}, 64'd0);
        if (pend && (mem_rd || mem_wr)) begin
          check("addr_stable", {49'd0, mem_addr}, {49'd0, pend_addr});
          if (mem_wr) check("wdata_stable", {48'd0, mem_wr_data}, {48'd0, pend_data});
        end
        if (mem_wr && mem_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %0h data %0h", mem_addr, mem_wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {49'd0, mem_addr}, {49'd0, e[AW+DW-1:DW]});
            check("wr_data", {48'd0, mem_wr_data}, {48'd0, e[DW-1:0]});
          end
        end
        pend      = (mem_rd || mem_wr) && !mem_ready;
        pend_addr = mem_addr;
        pend_data = mem_wr_data;
      end
    end
  end

  task automatic assert_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_instr_req", {63'd0, instr_req}, 64'd0);
    check("rst_mem_req", {62'd0, mem_rd, mem_wr}, 64'd0);
    check("rst_pc", {49'd0, instr_addr}, 64'd0);
    check("rst_a_d", {32'd0, dbg_a, dbg_d}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, FETCH});
    check("rst_cnt", {retired_cnt, stall_cnt}, 64'd0);
  endtask

  task automatic load_clear();
    for (int i = 0; i < 256; i++) imem[i] = '0;
    for (int i = 0; i < 16; i++)  dmem[i] = '0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_until_pc(input logic [AW-1:0] target, input int budget, output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(posedge clock);
      cycles++;
      @(negedge clock);
      #1;
      if (instr_addr == target && dbg_state == FETCH) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL timeout_pc: pc %0h never reached %0h", instr_addr, target);
    end
  endtask

  initial begin
    int cyc;
    load_clear();

    // Reset, then @5.
    imem[0] = 16'h0005;
    assert_reset();
    release_reset();
    check("first_req", {63'd0, instr_req}, 64'd1);
    check("first_addr", {49'd0, instr_addr}, 64'd0);
    run_until_pc(15'd1, 10, cyc);
    check("a_instr_cycles", cyc, 2);
    check("a_after_at5", {48'd0, dbg_a}, 64'd5);
    check("w24_imm", {40'd0, dbg_a_w}, 64'h7ABCDE);
    check("w24_pc", {44'd0, instr_addr_w}, 64'd1);

    // @7; D=A; @3; M=D
    assert_reset();
    load_clear();
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0003; imem[3] = 16'hE308;
    exp_q.push_back({15'd3, 16'd7});
    release_reset();
    run_until_pc(15'd4, 30, cyc);
    check("seq_cycles", cyc, 9);
    check("seq_d", {48'd0, dbg_d}, 64'd7);
    check("seq_mem3", {48'd0, dmem[3]}, 64'd7);

    // @3; AM=M+1 with two wait cycles per transaction.
    assert_reset();
    load_clear();
    dmem[3] = 16'd9;
    wait_n  = 2;
    imem[0] = 16'h0003; imem[1] = 16'hFDE8;
    exp_q.push_back({15'd3, 16'd10});
    release_reset();
    run_until_pc(15'd2, 40, cyc);
    check("rmw_cycles", cyc, 10);
    check("rmw_a", {48'd0, dbg_a}, 64'd10);
    check("rmw_mem3", {48'd0, dmem[3]}, 64'd10);
`ifdef HACK_CPU_MC_PERF_EN
    check("rmw_stall_cnt", {32'd0, stall_cnt}, 64'd4);
    check("rmw_retired_cnt", {32'd0, retired_cnt}, 64'd2);
`else
    check("rmw_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    check("rmw_retired_cnt", {32'd0, retired_cnt}, 64'd0);
`endif
    wait_n = 0;

    // D=-1; @100; D;JLT taken
    assert_reset();
    load_clear();
    imem[0] = 16'hEE90; imem[1] = 16'h0064; imem[2] = 16'hE304;
    release_reset();
    run_until_pc(15'd100, 30, cyc);
    check("jlt_taken_cycles", cyc, 6);
    check("jlt_d", {48'd0, dbg_d}, 64'hFFFF);

    // D=0; @100; D;JLT not taken
    assert_reset();
    load_clear();
    imem[0] = 16'hEA90; imem[1] = 16'h0064; imem[2] = 16'hE304;
    release_reset();
    run_until_pc(15'd3, 30, cyc);
    check("jlt_nt_cycles", cyc, 6);

    // D=0; @100; D;JEQ taken
    assert_reset();
    load_clear();
    imem[0] = 16'hEA90; imem[1] = 16'h0064; imem[2] = 16'hE302;
    release_reset();
    run_until_pc(15'd100, 30, cyc);
    check("jeq_cycles", cyc, 6);

    // Jump to top of PC range, then @1 wraps PC to 0.
    assert_reset();
    load_clear();
    imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[255] = 16'h0001;
    release_reset();
    run_until_pc(15'h7FFF, 30, cyc);
    check("jmp_top_cycles", cyc, 4);
    run_until_pc(15'd0, 30, cyc);
    check("wrap_cycles", cyc, 2);
    check("wrap_a", {48'd0, dbg_a}, 64'd1);

    // Reset while a write waits on mem_ready.
    assert_reset();
    load_clear();
    wait_n  = 100;
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0003; imem[3] = 16'hE308;
    release_reset();
    cyc = 0;
    while (dbg_state != WR && cyc < 30) begin
      @(negedge clock);
      #1;
      cyc++;
    end
    check("reach_wr", {62'd0, dbg_state}, {62'd0, WR});
    repeat (2) @(negedge clock);
    #1;
    check("wr_held", {63'd0, mem_wr}, 64'd1);
`ifdef HACK_CPU_MC_PERF_EN
    check("retired_before_abort", {32'd0, retired_cnt}, 64'd3);
`else
    check("retired_before_abort", {32'd0, retired_cnt}, 64'd0);
`endif
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("abort_mem_wr", {63'd0, mem_wr}, 64'd0);
    check("abort_a_d", {32'd0, dbg_a, dbg_d}, 64'd0);
    check("abort_pc", {49'd0, instr_addr}, 64'd0);
    check("abort_retired", {32'd0, retired_cnt}, 64'd0);
    check("abort_instr_req", {63'd0, instr_req}, 64'd0);

    repeat (3) @(negedge clock);
    check("exp_q_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
